// File: rtl/mem_lsu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_lsu_pkg : op codes, bus size codes and LSU FSM encodings     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package mem_lsu_pkg;

    localparam int          REG_BUS       = 32;
    localparam int          REG_ADDR_BUS  = 5;
    localparam int          ALU_OP_BUS    = 8;

    localparam logic [7:0]  c_EXE_LB_OP   = 8'b1110_0000;
    localparam logic [7:0]  c_EXE_LH_OP   = 8'b1110_0001;
    localparam logic [7:0]  c_EXE_LW_OP   = 8'b1110_0011;
    localparam logic [7:0]  c_EXE_LBU_OP  = 8'b1110_0100;
    localparam logic [7:0]  c_EXE_LHU_OP  = 8'b1110_0101;
    localparam logic [7:0]  c_EXE_SB_OP   = 8'b1110_1000;
    localparam logic [7:0]  c_EXE_SH_OP   = 8'b1110_1001;
    localparam logic [7:0]  c_EXE_SW_OP   = 8'b1110_1011;

    localparam logic [1:0]  c_SIZE_BYTE   = 2'd0;
    localparam logic [1:0]  c_SIZE_HALF   = 2'd1;
    localparam logic [1:0]  c_SIZE_WORD   = 2'd2;

    localparam logic        c_NO_STOP     = 1'b0;

    typedef enum logic [1:0] {
        LSU_IDLE  = 2'd0,
        LSU_WAIT  = 2'd1,
        LSU_DONE  = 2'd2,
        LSU_DRAIN = 2'd3
    } lsu_state_e;

    function automatic logic op_is_load(input logic [7:0] op);
        return (op == c_EXE_LB_OP)  || (op == c_EXE_LBU_OP) ||
               (op == c_EXE_LH_OP)  || (op == c_EXE_LHU_OP) ||
               (op == c_EXE_LW_OP);
    endfunction

    function automatic logic op_is_store(input logic [7:0] op);
        return (op == c_EXE_SB_OP) || (op == c_EXE_SH_OP) || (op == c_EXE_SW_OP);
    endfunction

    function automatic logic [1:0] op_size(input logic [7:0] op);
        case (op)
            c_EXE_LB_OP, c_EXE_LBU_OP, c_EXE_SB_OP: return c_SIZE_BYTE;
            c_EXE_LH_OP, c_EXE_LHU_OP, c_EXE_SH_OP: return c_SIZE_HALF;
            default:                                return c_SIZE_WORD;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_load_align.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_load_align : selects and extends the loaded byte/half/word   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module mem_load_align
    import mem_lsu_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr,
    input  logic [7:0]  i_aluop,
    output logic [31:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_addr)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];

        case (i_aluop)
            c_EXE_LB_OP:  o_result = {{24{w_byte[7]}}, w_byte};
            c_EXE_LBU_OP: o_result = {24'h0, w_byte};
            c_EXE_LH_OP:  o_result = {{16{w_half[15]}}, w_half};
            c_EXE_LHU_OP: o_result = {16'h0, w_half};
            default:      o_result = i_rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_lsu.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_lsu : MEM stage, slot-1 load/store over SRAM-like bus        |
// | Optional MEM_ALIGN_EXC_EN: raise address errors, else align addr |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module mem_lsu
    import mem_lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [3:0]  stall,
    input  logic [7:0]  aluop1_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  waddr1_i,
    input  logic        we1_i,
    input  logic [31:0] wdata1_i,
    input  logic [4:0]  waddr2_i,
    input  logic        we2_i,
    input  logic [31:0] wdata2_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    input  logic        whilo_i,
    input  logic [31:0] inst1_addr_i,
    input  logic [31:0] inst2_addr_i,
    output logic [4:0]  waddr1_o,
    output logic        we1_o,
    output logic [31:0] wdata1_o,
    output logic [4:0]  waddr2_o,
    output logic        we2_o,
    output logic [31:0] wdata2_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        whilo_o,
    output logic [31:0] inst1_addr_o,
    output logic [31:0] inst2_addr_o,
    output logic        stall_req_o,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic        adel_o,
    output logic        ades_o,
    output logic [31:0] badvaddr_o
);

    lsu_state_e  r_state;
    lsu_state_e  w_next;
    logic [31:0] r_rdata_q;

    logic        w_is_load;
    logic        w_is_store;
    logic        w_is_mem;
    logic        w_misalign;
    logic        w_access;
    logic [1:0]  w_size;
    logic [31:0] w_addr;
    logic [31:0] w_load_res;
    logic        w_req;
    logic        w_stall;
    logic        w_capture;
    logic        w_unused;

    assign w_is_load  = op_is_load(aluop1_i);
    assign w_is_store = op_is_store(aluop1_i);
    assign w_is_mem   = w_is_load | w_is_store;
    assign w_size     = op_size(aluop1_i);
    assign w_access   = w_is_mem & ~w_misalign;
    assign w_unused   = ^{stall[3], stall[1:0]};

`ifdef MEM_ALIGN_EXC_EN
    assign w_misalign = w_is_mem &&
                        (((w_size == c_SIZE_HALF) && mem_addr_i[0]) ||
                         ((w_size == c_SIZE_WORD) && (mem_addr_i[1:0] != 2'b00)));
    assign w_addr     = mem_addr_i;
    assign adel_o     = ~rst & w_is_load  & w_misalign;
    assign ades_o     = ~rst & w_is_store & w_misalign;
    assign badvaddr_o = (~rst & w_misalign) ? mem_addr_i : 32'h0;
`else
    assign w_misalign = 1'b0;
    // Without exceptions, misaligned accesses silently round down to the natural boundary
    always_comb begin
        w_addr = mem_addr_i;
        case (w_size)
            c_SIZE_HALF: w_addr[0]   = 1'b0;
            c_SIZE_WORD: w_addr[1:0] = 2'b00;
            default:     ;
        endcase
    end
    assign adel_o     = 1'b0;
    assign ades_o     = 1'b0;
    assign badvaddr_o = 32'h0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= LSU_IDLE;
            r_rdata_q <= '0;
        end else begin
            r_state <= w_next;
            if (w_capture) begin
                r_rdata_q <= data_rdata;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        w_req     = 1'b0;
        w_stall   = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            LSU_IDLE: begin
                if (w_access && !flush) begin
                    w_req   = 1'b1;
                    w_stall = 1'b1;
                    if (data_addr_ok) begin
                        w_next = LSU_WAIT;
                    end
                end
            end
            LSU_WAIT: begin
                w_stall = 1'b1;
                // A flushed access still owes one response; drain it unless it lands now
                if (flush) begin
                    w_next = data_data_ok ? LSU_IDLE : LSU_DRAIN;
                end else if (data_data_ok) begin
                    w_capture = 1'b1;
                    w_next    = LSU_DONE;
                end
            end
            LSU_DONE: begin
                if (flush || (stall[2] == c_NO_STOP)) begin
                    w_next = LSU_IDLE;
                end
            end
            default: begin
                w_stall = w_access;
                if (data_data_ok) begin
                    w_next = LSU_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        data_wstrb = 4'b0000;
        data_wdata = 32'h0;
        if (w_is_store) begin
            case (w_size)
                c_SIZE_BYTE: begin
                    data_wstrb = 4'b0001 << w_addr[1:0];
                    data_wdata = {4{reg2_i[7:0]}};
                end
                c_SIZE_HALF: begin
                    data_wstrb = w_addr[1] ? 4'b1100 : 4'b0011;
                    data_wdata = {2{reg2_i[15:0]}};
                end
                default: begin
                    data_wstrb = 4'b1111;
                    data_wdata = reg2_i;
                end
            endcase
        end
    end

    mem_load_align u_load_align (
        .i_rdata  (r_rdata_q),
        .i_addr   (w_addr[1:0]),
        .i_aluop  (aluop1_i),
        .o_result (w_load_res)
    );

    assign data_req     = w_req & ~rst;
    assign stall_req_o  = w_stall & ~rst;
    assign data_wr      = w_is_store;
    assign data_size    = w_size;
    assign data_addr    = w_addr;

    assign waddr1_o     = waddr1_i;
    assign we1_o        = we1_i & ~w_misalign;
    assign wdata1_o     = (~rst && (r_state == LSU_DONE) && w_is_load) ? w_load_res : wdata1_i;
    assign waddr2_o     = waddr2_i;
    assign we2_o        = we2_i;
    assign wdata2_o     = wdata2_i;
    assign hi_o         = hi_i;
    assign lo_o         = lo_i;
    assign whilo_o      = whilo_i;
    assign inst1_addr_o = inst1_addr_i;
    assign inst2_addr_o = inst2_addr_i;

endmodule
`default_nettype wire
